cachek: RTL and testbench
=========================

# cachek

Direct-mapped cache data/tag store: 16 lines × 4 words × 16 bits, each line with a 5-bit tag, a valid bit and a dirty bit. It serves as the storage bank under a cache controller, which issues one access/compare read or write per enabled cycle. The bank returns hit, line status and the addressed word one clock later. A bulk reset invalidates every line and is acknowledged on `ack`.

## Interface
- No parameters; geometry is fixed: 16 lines, 4 words per line, 16-bit words, 5-bit tags.
- All vectors are declared `[0:N-1]`; bit 0 is the MSB.
- clk  in  1  single clock; all state and outputs update on the rising edge.
- rst  in  1  synchronous, active-high reset; also the bulk-invalidate command.
- enable  in  1  operation strobe; inputs are sampled only when 1 (or when rst=1).
- index  in  4  line select, 0..15.
- word  in  2  word-within-line select, 0..3.
- cmp  in  1  1 = compare (tag-checked) operation; 0 = direct access.
- write  in  1  1 = write; 0 = read.
- tag  in  5  tag for compare, or the tag to store on an access write.
- data_in  in  16  write data.
- valid_in  in  1  valid bit to store on an access write.
- hit  out  1  compare operation hit (line valid and tags equal).
- dirty  out  1  dirty bit of the addressed line.
- tag_out  out  5  stored tag of the addressed line.
- data_out  out  16  stored addressed word.
- valid  out  1  valid bit of the addressed line.
- ack  out  1  operation/reset complete strobe.

## Operation
- Priority: rst over enable. With rst=0 and enable=0, no state change occurs, hit=0, ack=0, and other outputs hold.
- `dirty`, `tag_out`, `valid` and `data_out` are the addressed line's contents before the current edge's write; `data_out` is word `word` of that line.
- Access read (cmp=0, write=0):
  - Outputs the line status and word; no state change; hit=0.
- Access write (cmp=0, write=1):
  - word[word] <= data_in, tag <= tag, valid <= valid_in, dirty <= 0.
  - hit=0.
- Compare read (cmp=1, write=0):
  - hit = stored valid AND (stored tag == tag).
  - No state change.
- Compare write (cmp=1, write=1):
  - hit as for compare read.
  - On hit: word[word] <= data_in, dirty <= 1; tag and valid unchanged.
  - On miss: no state change.
- Reset (rst=1, enable ignored):
  - All 16 valid and dirty bits are cleared.
  - Data and tag arrays are not cleared; their contents are don't-care.
- `ack` is 1 the cycle after any enabled operation or any reset edge.
- An access write with valid_in=0 invalidates the line; later compares on that line miss.

## Timing
- Latency is one clock: inputs sampled at edge N produce outputs valid after edge N, held until edge N+1.
- Reset:
  - Every rst=1 edge clears the arrays in that same edge.
  - Outputs after that edge: hit=0, dirty=0, valid=0, tag_out=0, data_out=0, ack=1.
  - ack stays 1 while rst is held; after rst deasserts it follows the enable rule.
- Back-to-back operations on consecutive edges are allowed.
- A read on the edge after a write to the same line/word returns the new data.
- Simultaneous rst and enable: reset wins and the operation is dropped.
- No wrap-around or full/empty conditions; all index/word codes are legal.

## Test plan
- Access write, then compare read:
  - Stimulus: rst, then access write index 0, word 3, tag 11101, data 0x0F0F, valid_in 1; then compare read with the same address and tag.
  - Required: hit=1, data_out=0x0F0F, tag_out=11101, valid=1, dirty=0, ack=1.
- Reset invalidates a written line:
  - Stimulus: after the write above, rst=1 until ack=1, release rst, then compare read index 0, word 3, tag 11101.
  - Required: hit=0, valid=0, dirty=0.
- Compare write hit, then compare read:
  - Stimulus: compare write hit on index 5, word 1, data 0xBEEF; then compare read of the same location.
  - Required: compare write returns hit=1; the read returns data_out=0xBEEF, dirty=1.
- Compare write on tag mismatch:
  - Stimulus: tag 00001 against a stored tag 11101.
  - Required: hit=0; the stored word and dirty bit are unchanged.
- Word isolation:
  - Stimulus: access writes of 0x1111, 0x2222, 0x3333, 0x4444 to words 0-3 of index 15; read each word back.
  - Required: each word returns its own value.
- enable=0 hold:
  - Stimulus: drive enable=0 for 3 cycles with changing index and write inputs.
  - Required: no state change, hit=0, ack=0.

Source files
------------

// File: rtl/cachek.sv
// Direct-mapped cache data/tag store: 16 lines x 4 words x 16 bits, each line
// with a 5-bit tag, valid and dirty bit. Outputs are registered, one clock of latency.
module cachek (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [0:3]  index,
  input  logic [0:1]  word,
  input  logic        cmp,
  input  logic        write,
  input  logic [0:4]  tag,
  input  logic [0:15] data_in,
  input  logic        valid_in,
  output logic        hit,
  output logic        dirty,
  output logic [0:4]  tag_out,
  output logic [0:15] data_out,
  output logic        valid,
  output logic        ack
);

  logic [0:15] data_mem [16][4];
  logic [0:4]  tag_mem  [16];
  logic [15:0] valid_bits;
  logic [15:0] dirty_bits;

  logic line_hit;
  logic op_en;
  logic mem_we;

  assign line_hit = valid_bits[index] && (tag_mem[index] == tag);
  assign op_en    = enable && !rst;
  // Access writes always land; compare writes land only on a hit.
  assign mem_we   = op_en && write && (!cmp || line_hit);

  // NOTE: the data and tag arrays have no reset so they map onto plain RAM;
  // only the per-line valid/dirty flags need clearing for a bulk invalidate.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      data_mem[index][word] <= data_in;
      if (!cmp) tag_mem[index] <= tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every read in this
  // block sees the pre-edge value, which gives the read-before-write outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (enable && write) begin
      if (!cmp) begin
        valid_bits[index] <= valid_in;
        dirty_bits[index] <= 1'b0;
      end else if (line_hit) begin
        dirty_bits[index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit      <= 1'b0;
      dirty    <= 1'b0;
      tag_out  <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      ack      <= 1'b1;
    end else if (enable) begin
      hit      <= cmp && line_hit;
      dirty    <= dirty_bits[index];
      tag_out  <= tag_mem[index];
      data_out <= data_mem[index][word];
      valid    <= valid_bits[index];
      ack      <= 1'b1;
    end else begin
      // Idle cycle: status outputs hold, strobes drop.
      hit <= 1'b0;
      ack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cachek.sv
// Self-checking bench for cachek: a directed vector table for the documented
// scenarios, then random traffic against an array-based reference model.
module tb_cachek;

  logic        clk = 1'b0;
  logic        rst, enable, cmp, write, valid_in;
  logic [0:3]  index;
  logic [0:1]  word;
  logic [0:4]  tag;
  logic [0:15] data_in;
  logic        hit, dirty, valid, ack;
  logic [0:4]  tag_out;
  logic [0:15] data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cachek dut (
    .clk(clk), .rst(rst), .enable(enable), .index(index), .word(word),
    .cmp(cmp), .write(write), .tag(tag), .data_in(data_in), .valid_in(valid_in),
    .hit(hit), .dirty(dirty), .tag_out(tag_out), .data_out(data_out),
    .valid(valid), .ack(ack)
  );

  typedef struct {
    logic        rst, en, cmp, wr;
    logic [3:0]  idx;
    logic [1:0]  wd;
    logic [4:0]  tg;
    logic [15:0] din;
    logic        vin;
    logic        e_hit, e_dirty, e_valid, e_ack;
    logic        ck_tag;
    logic [4:0]  e_tag;
    logic        ck_data;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, e, c, w, input logic [3:0] i, input logic [1:0] wd,
    input logic [4:0] t, input logic [15:0] d, input logic vi,
    input logic eh, ed, ev, ea, input logic ckt, input logic [4:0] et,
    input logic ckd, input logic [15:0] edat);
    vec_t v;
    v.rst = r; v.en = e; v.cmp = c; v.wr = w; v.idx = i; v.wd = wd; v.tg = t;
    v.din = d; v.vin = vi; v.e_hit = eh; v.e_dirty = ed; v.e_valid = ev;
    v.e_ack = ea; v.ck_tag = ckt; v.e_tag = et; v.ck_data = ckd; v.e_data = edat;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, e, c, w, input logic [3:0] i, input logic [1:0] wd,
                       input logic [4:0] t, input logic [15:0] d, input logic vi);
    rst = r; enable = e; cmp = c; write = w; index = i; word = wd;
    tag = t; data_in = d; valid_in = vi;
  endtask

  // Reference model state.
  logic [15:0] m_data [16][4];
  logic [4:0]  m_tag  [16];
  bit          k_data [16][4];
  bit          k_tag  [16];
  bit          m_valid[16];
  bit          m_dirty[16];
  logic        x_hit, x_dirty, x_valid, x_ack;
  logic [4:0]  x_tag;
  logic [15:0] x_data;
  bit          xk_tag, xk_data;

  task automatic model_step(input logic r, e, c, w, input int i, input int wd,
                            input logic [4:0] t, input logic [15:0] d, input logic vi);
    bit lh;
    if (r) begin
      for (int n = 0; n < 16; n++) begin
        m_valid[n] = 0; m_dirty[n] = 0; k_tag[n] = 0;
        for (int k = 0; k < 4; k++) k_data[n][k] = 0;
      end
      x_hit = 0; x_dirty = 0; x_valid = 0; x_ack = 1; x_tag = '0; x_data = '0;
      xk_tag = 1; xk_data = 1;
    end else if (e) begin
      lh = m_valid[i] && (m_tag[i] == t);
      x_hit = c && lh; x_dirty = m_dirty[i]; x_valid = m_valid[i]; x_ack = 1;
      x_tag = m_tag[i]; xk_tag = k_tag[i];
      x_data = m_data[i][wd]; xk_data = k_data[i][wd];
      if (w && !c) begin
        m_data[i][wd] = d; k_data[i][wd] = 1; m_tag[i] = t; k_tag[i] = 1;
        m_valid[i] = vi; m_dirty[i] = 0;
      end else if (w && c && lh) begin
        m_data[i][wd] = d; k_data[i][wd] = 1; m_dirty[i] = 1;
      end
    end else begin
      x_hit = 0; x_ack = 0;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // rst en cmp wr idx wd tag din vin | hit dirty valid ack | ckt tag | ckd data
    vecs.push_back(mk(1,0,0,0, 0,0,5'b00000,16'h0000,0, 0,0,0,1, 1,5'b00000, 1,16'h0000));
    vecs.push_back(mk(0,1,0,1, 0,3,5'b11101,16'h0F0F,1, 0,0,0,1, 0,5'b00000, 0,16'h0000));
    vecs.push_back(mk(0,1,1,0, 0,3,5'b11101,16'h0000,0, 1,0,1,1, 1,5'b11101, 1,16'h0F0F));
    vecs.push_back(mk(1,0,0,0, 0,0,5'b00000,16'h0000,0, 0,0,0,1, 1,5'b00000, 1,16'h0000));
    vecs.push_back(mk(1,0,0,0, 3,2,5'b10101,16'hAAAA,0, 0,0,0,1, 1,5'b00000, 1,16'h0000));
    vecs.push_back(mk(0,1,1,0, 0,3,5'b11101,16'h0000,0, 0,0,0,1, 0,5'b00000, 0,16'h0000));
    vecs.push_back(mk(0,1,0,1, 5,1,5'b11101,16'h1234,1, 0,0,0,1, 0,5'b00000, 0,16'h0000));
    vecs.push_back(mk(0,1,1,1, 5,1,5'b11101,16'hBEEF,0, 1,0,1,1, 1,5'b11101, 1,16'h1234));
    vecs.push_back(mk(0,1,1,0, 5,1,5'b11101,16'h0000,0, 1,1,1,1, 1,5'b11101, 1,16'hBEEF));
    vecs.push_back(mk(0,1,1,1, 5,1,5'b00001,16'hDEAD,0, 0,1,1,1, 1,5'b11101, 1,16'hBEEF));
    vecs.push_back(mk(0,1,1,0, 5,1,5'b11101,16'h0000,0, 1,1,1,1, 1,5'b11101, 1,16'hBEEF));
    vecs.push_back(mk(0,1,0,1,15,0,5'b00011,16'h1111,1, 0,0,0,1, 0,5'b00000, 0,16'h0000));
    vecs.push_back(mk(0,1,0,1,15,1,5'b00011,16'h2222,1, 0,0,1,1, 1,5'b00011, 0,16'h0000));
    vecs.push_back(mk(0,1,0,1,15,2,5'b00011,16'h3333,1, 0,0,1,1, 1,5'b00011, 0,16'h0000));
    vecs.push_back(mk(0,1,0,1,15,3,5'b00011,16'h4444,1, 0,0,1,1, 1,5'b00011, 0,16'h0000));
    vecs.push_back(mk(0,1,0,0,15,0,5'b00000,16'h0000,0, 0,0,1,1, 1,5'b00011, 1,16'h1111));
    vecs.push_back(mk(0,1,0,0,15,1,5'b00000,16'h0000,0, 0,0,1,1, 1,5'b00011, 1,16'h2222));
    vecs.push_back(mk(0,1,0,0,15,2,5'b00000,16'h0000,0, 0,0,1,1, 1,5'b00011, 1,16'h3333));
    vecs.push_back(mk(0,1,0,0,15,3,5'b00000,16'h0000,0, 0,0,1,1, 1,5'b00011, 1,16'h4444));
    vecs.push_back(mk(0,0,0,1,15,0,5'b11111,16'hFFFF,1, 0,0,1,0, 1,5'b00011, 1,16'h4444));
    vecs.push_back(mk(0,0,1,1, 2,1,5'b00000,16'hEEEE,0, 0,0,1,0, 1,5'b00011, 1,16'h4444));
    vecs.push_back(mk(0,0,0,1, 7,2,5'b01010,16'hDDDD,1, 0,0,1,0, 1,5'b00011, 1,16'h4444));
    vecs.push_back(mk(0,1,0,0,15,0,5'b00000,16'h0000,0, 0,0,1,1, 1,5'b00011, 1,16'h1111));
    vecs.push_back(mk(0,1,0,1,15,2,5'b00011,16'h5555,0, 0,0,1,1, 1,5'b00011, 1,16'h3333));
    vecs.push_back(mk(0,1,1,0,15,2,5'b00011,16'h0000,0, 0,0,0,1, 1,5'b00011, 1,16'h5555));
    vecs.push_back(mk(1,1,0,1,15,1,5'b00011,16'h9999,1, 0,0,0,1, 1,5'b00000, 1,16'h0000));
    vecs.push_back(mk(0,1,1,0,15,1,5'b00011,16'h0000,0, 0,0,0,1, 0,5'b00000, 0,16'h0000));

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].rst, vecs[n].en, vecs[n].cmp, vecs[n].wr, vecs[n].idx, vecs[n].wd,
            vecs[n].tg, vecs[n].din, vecs[n].vin);
      @(posedge clk); #1;
      check($sformatf("v%0d hit", n),   16'(hit),   16'(vecs[n].e_hit));
      check($sformatf("v%0d dirty", n), 16'(dirty), 16'(vecs[n].e_dirty));
      check($sformatf("v%0d valid", n), 16'(valid), 16'(vecs[n].e_valid));
      check($sformatf("v%0d ack", n),   16'(ack),   16'(vecs[n].e_ack));
      if (vecs[n].ck_tag)  check($sformatf("v%0d tag_out", n), 16'(tag_out), 16'(vecs[n].e_tag));
      if (vecs[n].ck_data) check($sformatf("v%0d data_out", n), data_out, vecs[n].e_data);
    end

    // Random traffic; the first cycle is a reset so the model starts in step.
    for (int n = 0; n < 600; n++) begin
      logic r, e, c, w, vi;
      int i, wd;
      logic [4:0] t;
      logic [15:0] d;
      r  = (n == 0) || ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 3) != 0);
      c  = $urandom_range(0, 1);
      w  = $urandom_range(0, 1);
      i  = $urandom_range(0, 7);
      wd = $urandom_range(0, 3);
      t  = 5'($urandom_range(0, 3));
      d  = 16'($urandom);
      vi = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      drive(r, e, c, w, 4'(i), 2'(wd), t, d, vi);
      model_step(r, e, c, w, i, wd, t, d, vi);
      @(posedge clk); #1;
      check($sformatf("r%0d hit", n),   16'(hit),   16'(x_hit));
      check($sformatf("r%0d dirty", n), 16'(dirty), 16'(x_dirty));
      check($sformatf("r%0d valid", n), 16'(valid), 16'(x_valid));
      check($sformatf("r%0d ack", n),   16'(ack),   16'(x_ack));
      if (xk_tag)  check($sformatf("r%0d tag_out", n), 16'(tag_out), 16'(x_tag));
      if (xk_data) check($sformatf("r%0d data_out", n), data_out, x_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
